// File: rtl/lsu_arbiter.sv
// -----------------------------------------------------------------------------
// lsu_arbiter
//
// Two-lane load/store arbiter and sequencer in front of one shared data-memory
// port. It takes one op at a time from the two VLIW lanes, choosing between them
// round-robin. It drives the memory request/grant handshake. It builds byte
// enables and replicated store data, and aligns and extends load data. Load
// results go back to the owning lane with the destination tag. Misaligned or
// illegal-size ops are flagged and never reach memory.
//
// Optional feature macro: LSU_ARB_STORE_ACK_EN
//   When it is defined, a granted store also produces a one-cycle response:
//   resp_valid=1, resp_store=1, resp_data=0, and resp_rd set to the store's tag.
//   When it is undefined, stores complete silently and resp_store is tied to 0.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   req_*         per-lane decoded memory ops (bit/slice i belongs to lane i)
//   req_ready     per-lane accept, at most one bit high, only while IDLE
//   mem_*         shared memory port: request held until mem_gnt; mem_rvalid
//                 and mem_rdata return load data
//   resp_*        one-cycle result pulse with lane, tag and extended data
//   err_valid/lane one-cycle fault pulse for misaligned or illegal-size ops
// -----------------------------------------------------------------------------
module lsu_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_is_load,
  input  logic [1:0]          req_zero_ext,
  input  logic [3:0]          req_size,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [63:0]         req_wdata,
  input  logic [9:0]          req_rd,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [3:0]          mem_be,
  output logic [31:0]         mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [31:0]         mem_rdata,
  output logic                resp_valid,
  output logic                resp_lane,
  output logic [4:0]          resp_rd,
  output logic [31:0]         resp_data,
  output logic                resp_store,
  output logic                err_valid,
  output logic                err_lane
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_RESP = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // ---------------------------------------------------------------------------
  // Per-lane views of the packed request buses
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] lane_addr  [2];
  logic [31:0]       lane_wdata [2];
  logic [4:0]        lane_rd    [2];
  logic [1:0]        lane_size  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign lane_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign lane_wdata[gi] = req_wdata[gi*32 +: 32];
    assign lane_rd[gi]    = req_rd[gi*5 +: 5];
    assign lane_size[gi]  = req_size[gi*2 +: 2];
  end

  // ---------------------------------------------------------------------------
  // State and captured-op registers
  // ---------------------------------------------------------------------------
  state_t            state_q,     state_d;
  logic              last_lane_q, last_lane_d;
  logic              lane_q,      lane_d;
  logic              is_load_q,   is_load_d;
  logic              zext_q,      zext_d;
  logic [1:0]        size_q,      size_d;
  logic [1:0]        off_q,       off_d;
  logic [4:0]        rd_q,        rd_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [3:0]        mem_be_q,    mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       data_q,      data_d;

  // ---------------------------------------------------------------------------
  // Arbitration and decode of the selected lane
  // ---------------------------------------------------------------------------
  logic              sel_lane;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic [1:0]        sel_off;
  logic [31:0]       sel_wdata;
  logic              sel_fault;
  logic [3:0]        sel_be;
  logic [31:0]       sel_wdata_rep;

  always_comb begin
    // On a conflict the lane that did not win last time goes first. With only
    // one lane valid, that lane wins.
    sel_lane  = (&req_valid) ? ~last_lane_q : req_valid[1];
    // req_ready is held low throughout reset, even though the state is IDLE.
    accept    = (state_q == S_IDLE) && (|req_valid) && !rst;
    req_ready = accept ? (sel_lane ? 2'b10 : 2'b01) : 2'b00;

    sel_addr  = lane_addr[sel_lane];
    sel_size  = lane_size[sel_lane];
    sel_wdata = lane_wdata[sel_lane];
    sel_off   = sel_addr[1:0];

    sel_fault = (sel_size == SZ_ILL) ||
                ((sel_size == SZ_HALF) && sel_off[0]) ||
                ((sel_size == SZ_WORD) && (sel_off != 2'b00));

    case (sel_size)
      SZ_BYTE: begin
        sel_be        = 4'b0001 << sel_off;
        sel_wdata_rep = {4{sel_wdata[7:0]}};
      end
      SZ_HALF: begin
        sel_be        = sel_off[1] ? 4'b1100 : 4'b0011;
        sel_wdata_rep = {2{sel_wdata[15:0]}};
      end
      default: begin
        sel_be        = 4'b1111;
        sel_wdata_rep = sel_wdata;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load-data alignment and extension
  // ---------------------------------------------------------------------------
  logic [31:0] rdata_shift;
  logic [31:0] load_ext;

  always_comb begin
    rdata_shift = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      SZ_BYTE: load_ext = {{24{~zext_q & rdata_shift[7]}},  rdata_shift[7:0]};
      SZ_HALF: load_ext = {{16{~zext_q & rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_ext = rdata_shift;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    last_lane_d = last_lane_q;
    lane_d      = lane_q;
    is_load_d   = is_load_q;
    zext_d      = zext_q;
    size_d      = size_q;
    off_d       = off_q;
    rd_d        = rd_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    data_d      = data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          last_lane_d = sel_lane;
          lane_d      = sel_lane;
          is_load_d   = req_is_load[sel_lane];
          zext_d      = req_zero_ext[sel_lane];
          size_d      = sel_size;
          off_d       = sel_off;
          rd_d        = lane_rd[sel_lane];
          if (sel_fault) begin
            // A faulting op never touches the memory-side registers.
            state_d = S_ERR;
          end else begin
            state_d     = S_REQ;
            mem_addr_d  = {sel_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = sel_be;
            mem_wdata_d = sel_wdata_rep;
          end
        end
      end

      S_REQ: begin
        // mem_rvalid is deliberately not looked at here, even in the grant
        // cycle.
        if (mem_gnt) begin
          if (is_load_q) begin
            state_d = S_WAIT;
          end else begin
`ifdef LSU_ARB_STORE_ACK_EN
            state_d = S_RESP;
            data_d  = 32'd0;
`else
            state_d = S_IDLE;
`endif
          end
        end
      end

      S_WAIT: begin
        if (mem_rvalid) begin
          data_d  = load_ext;
          state_d = S_RESP;
        end
      end

      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_lane_q <= 1'b1;  // lane 0 wins the first conflict
      lane_q      <= 1'b0;
      is_load_q   <= 1'b0;
      zext_q      <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      rd_q        <= 5'd0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      data_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      last_lane_q <= last_lane_d;
      lane_q      <= lane_d;
      is_load_q   <= is_load_d;
      zext_q      <= zext_d;
      size_q      <= size_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      data_q      <= data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so none depend on the
  // memory-side inputs in the same cycle.
  // ---------------------------------------------------------------------------
  assign mem_req    = (state_q == S_REQ);
  assign mem_we     = mem_req & ~is_load_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

  assign resp_valid = (state_q == S_RESP);
  assign resp_lane  = resp_valid & lane_q;
  assign resp_rd    = resp_valid ? rd_q : 5'd0;
  assign resp_data  = resp_valid ? data_q : 32'd0;
`ifdef LSU_ARB_STORE_ACK_EN
  assign resp_store = resp_valid & ~is_load_q;
`else
  assign resp_store = 1'b0;
`endif

  assign err_valid  = (state_q == S_ERR);
  assign err_lane   = err_valid & lane_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lsu_arbiter
//
// Directed testbench for lsu_arbiter. The stimulus code pushes hand-computed
// expectations into queues. A monitor that runs on the falling edge pops an
// expectation whenever the DUT raises mem_req, resp_valid or err_valid, and
// compares the DUT outputs and the cycle number against it.
// -----------------------------------------------------------------------------
module tb_lsu_arbiter;
  localparam int AW = 32;
`ifdef LSU_ARB_STORE_ACK_EN
  localparam int STORE_GAP = 2;
`else
  localparam int STORE_GAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_is_load;
  logic [1:0]    req_zero_ext;
  logic [3:0]    req_size;
  logic [2*AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic [9:0]    req_rd;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_gnt, mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          resp_valid, resp_lane, resp_store, err_valid, err_lane;
  logic [4:0]    resp_rd;
  logic [31:0]   resp_data;

  lsu_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_load(req_is_load),
    .req_zero_ext(req_zero_ext), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_lane(resp_lane), .resp_rd(resp_rd),
    .resp_data(resp_data), .resp_store(resp_store),
    .err_valid(err_valid), .err_lane(err_lane)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wd;
    int          cyc;
  } mem_exp_t;

  typedef struct {
    logic        lane;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        store;
    int          cyc;
  } resp_exp_t;

  typedef struct {
    logic lane;
    int   cyc;
  } err_exp_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];
  err_exp_t  err_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: output asserted with nothing expected (cycle %0d)", name, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic mreq_prev = 1'b0;
  always @(negedge clk) begin
    mem_exp_t  me;
    resp_exp_t re;
    err_exp_t  ee;
    if (mem_req && !mreq_prev) begin
      if (mem_q.size() == 0) unexpected("mem_req_unexpected");
      else begin
        me = mem_q.pop_front();
        chk("mem_we", {31'd0, mem_we}, {31'd0, me.we});
        chk("mem_addr", mem_addr, me.addr);
        chk("mem_be", {28'd0, mem_be}, {28'd0, me.be});
        if (me.chk_wd) chk("mem_wdata", mem_wdata, me.wdata);
        chk("mem_req_cycle", cyc, me.cyc);
        $display("mem  req  cyc=%0d we=%0b addr=0x%08h be=%b wdata=0x%08h",
                 cyc, mem_we, mem_addr, mem_be, mem_wdata);
      end
    end
    mreq_prev = mem_req;
    if (resp_valid) begin
      if (resp_q.size() == 0) unexpected("resp_valid_unexpected");
      else begin
        re = resp_q.pop_front();
        chk("resp_lane", {31'd0, resp_lane}, {31'd0, re.lane});
        chk("resp_rd", {27'd0, resp_rd}, {27'd0, re.rd});
        chk("resp_data", resp_data, re.data);
        chk("resp_store", {31'd0, resp_store}, {31'd0, re.store});
        chk("resp_cycle", cyc, re.cyc);
        $display("resp      cyc=%0d lane=%0b rd=%0d data=0x%08h store=%0b",
                 cyc, resp_lane, resp_rd, resp_data, resp_store);
      end
    end
    if (err_valid) begin
      if (err_q.size() == 0) unexpected("err_valid_unexpected");
      else begin
        ee = err_q.pop_front();
        chk("err_lane", {31'd0, err_lane}, {31'd0, ee.lane});
        chk("err_cycle", cyc, ee.cyc);
        $display("err       cyc=%0d lane=%0b", cyc, err_lane);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic ld, input logic zx, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    req_is_load[l]         = ld;
    req_zero_ext[l]        = zx;
    req_size[2*l +: 2]     = sz;
    req_addr[AW*l +: AW]   = a;
    req_wdata[32*l +: 32]  = wd;
    req_rd[5*l +: 5]       = rd;
  endtask

  // Raise the lanes in mask until one of them is accepted. Return the lane that
  // won and the cycle in which it was accepted.
  task automatic accept(input logic [1:0] mask, output logic lane, output int acc);
    bit done;
    done = 1'b0;
    lane = 1'b0;
    acc  = 0;
    req_valid = mask;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        done = 1'b1;
        lane = req_ready[1];
        acc  = cyc;
      end
      tick();
    end
    req_valid = 2'b00;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: req_ready got 00 expected nonzero for mask %b", mask);
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !mem_req; i++) tick();
    chk("mem_req_seen", {31'd0, mem_req}, 32'd1);
  endtask

  task automatic store_phase(input logic lane, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wd, input logic [4:0] rd, input int acc,
                             input int gnt_dly, output int gnt_cyc);
    mem_exp_t e;
`ifdef LSU_ARB_STORE_ACK_EN
    resp_exp_t r;
`endif
    e.we = 1'b1; e.addr = addr; e.be = be; e.wdata = wd; e.chk_wd = 1'b1; e.cyc = acc + 1;
    mem_q.push_back(e);
    wait_req();
    repeat (gnt_dly) tick();
    mem_gnt = 1'b1;
    gnt_cyc = cyc;
`ifdef LSU_ARB_STORE_ACK_EN
    r.lane = lane; r.rd = rd; r.data = 32'd0; r.store = 1'b1; r.cyc = gnt_cyc + 1;
    resp_q.push_back(r);
`endif
    tick();
    mem_gnt = 1'b0;
  endtask

  task automatic load_phase(input logic lane, input logic [31:0] addr, input logic [3:0] be,
                            input logic [4:0] rd, input logic [31:0] rdata,
                            input logic [31:0] exp_data, input int acc, input int gnt_dly,
                            input int rv_dly, input bit garbage, output int rv_cyc);
    mem_exp_t  e;
    resp_exp_t r;
    e.we = 1'b0; e.addr = addr; e.be = be; e.wdata = 32'd0; e.chk_wd = 1'b0; e.cyc = acc + 1;
    mem_q.push_back(e);
    wait_req();
    repeat (gnt_dly) tick();
    mem_gnt = 1'b1;
    if (garbage) begin
      // Read data presented together with the grant must be ignored.
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
    end
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    repeat (rv_dly) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    rv_cyc     = cyc;
    r.lane = lane; r.rd = rd; r.data = exp_data; r.store = 1'b0; r.cyc = rv_cyc + 1;
    resp_q.push_back(r);
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic got;
    int   acc, prev, gnt, rvc;
    int   arb_exp [4] = '{0, 1, 0, 1};
    mem_exp_t e;

    rst = 1'b1; req_valid = 2'b11; req_is_load = 2'b00; req_zero_ext = 2'b00;
    req_size = 4'd0; req_addr = '0; req_wdata = 64'd0; req_rd = 10'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) tick();
    #1;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp", {resp_valid, resp_lane, resp_store, resp_rd, resp_data[23:0]}, 32'd0);
    chk("rst_err", {30'd0, err_valid, err_lane}, 32'd0);
    req_valid = 2'b00;
    rst = 1'b0;
    tick();

    // Both lanes issue SB with data 0xAB: grants must alternate 0,1,0,1.
    set_lane(0, 1'b0, 1'b0, 2'b00, 32'h0000_0200, 32'h0000_00AB, 5'd7);
    set_lane(1, 1'b0, 1'b0, 2'b00, 32'h0000_0301, 32'h0000_00AB, 5'd9);
    gnt = 0;
    for (int k = 0; k < 4; k++) begin
      accept(2'b11, got, acc);
      chk("arb_lane", {31'd0, got}, arb_exp[k]);
      if (k > 0) chk("store_next_accept", acc, gnt + STORE_GAP);
      if (arb_exp[k] == 1)
        store_phase(1'b1, 32'h0000_0300, 4'b0010, 32'hABAB_ABAB, 5'd9, acc, 0, gnt);
      else
        store_phase(1'b0, 32'h0000_0200, 4'b0001, 32'hABAB_ABAB, 5'd7, acc, 0, gnt);
    end
    tick();

    // LB on lane 0 at 0x103: grant at +2, rvalid at +4, response at +5.
    set_lane(0, 1'b1, 1'b0, 2'b00, 32'h0000_0103, 32'd0, 5'd3);
    accept(2'b01, got, acc);
    chk("lb_lane", {31'd0, got}, 32'd0);
    load_phase(1'b0, 32'h0000_0100, 4'b1000, 5'd3, 32'h80FF_FF11, 32'hFFFF_FF80,
               acc, 1, 1, 1'b0, rvc);

    // LHU on lane 1 at 0x2, with stray read data during the grant cycle.
    set_lane(1, 1'b1, 1'b1, 2'b01, 32'h0000_0002, 32'd0, 5'd17);
    accept(2'b10, got, acc);
    chk("load_next_accept", acc, rvc + 2);
    load_phase(1'b1, 32'h0000_0000, 4'b1100, 5'd17, 32'h8001_0000, 32'h0000_8001,
               acc, 0, 2, 1'b1, rvc);

    // LH on lane 0 at 0x10 (sign-extended).
    set_lane(0, 1'b1, 1'b0, 2'b01, 32'h0000_0010, 32'd0, 5'd20);
    accept(2'b01, got, acc);
    chk("load_next_accept2", acc, rvc + 2);
    load_phase(1'b0, 32'h0000_0010, 4'b0011, 5'd20, 32'h1234_F00D, 32'hFFFF_F00D,
               acc, 0, 0, 1'b0, rvc);

    // LBU on lane 0 at 0x41.
    set_lane(0, 1'b1, 1'b1, 2'b00, 32'h0000_0041, 32'd0, 5'd21);
    accept(2'b01, got, acc);
    load_phase(1'b0, 32'h0000_0040, 4'b0010, 5'd21, 32'h0000_9900, 32'h0000_0099,
               acc, 0, 0, 1'b0, rvc);

    // LB on lane 1 at 0x42, positive byte.
    set_lane(1, 1'b1, 1'b0, 2'b00, 32'h0000_0042, 32'd0, 5'd22);
    accept(2'b10, got, acc);
    load_phase(1'b1, 32'h0000_0040, 4'b0100, 5'd22, 32'h807F_0000, 32'h0000_007F,
               acc, 0, 0, 1'b0, rvc);

    // LW on lane 1 at 0x24.
    set_lane(1, 1'b1, 1'b0, 2'b10, 32'h0000_0024, 32'd0, 5'd31);
    accept(2'b10, got, acc);
    load_phase(1'b1, 32'h0000_0024, 4'b1111, 5'd31, 32'hCAFE_BABE, 32'hCAFE_BABE,
               acc, 1, 0, 1'b0, rvc);

    // Faults: SW at 0x6 on lane 1, illegal size on lane 0, LH at 0x83 on lane 0.
    set_lane(1, 1'b0, 1'b0, 2'b10, 32'h0000_0006, 32'h1111_2222, 5'd1);
    accept(2'b10, got, acc);
    chk("sw_mis_lane", {31'd0, got}, 32'd1);
    err_q.push_back('{lane: 1'b1, cyc: acc + 1});
    prev = acc;
    set_lane(0, 1'b1, 1'b0, 2'b11, 32'h0000_0080, 32'd0, 5'd2);
    accept(2'b01, got, acc);
    chk("err_next_accept", acc, prev + 2);
    err_q.push_back('{lane: 1'b0, cyc: acc + 1});
    prev = acc;
    set_lane(0, 1'b1, 1'b0, 2'b01, 32'h0000_0083, 32'd0, 5'd3);
    accept(2'b01, got, acc);
    chk("err_next_accept2", acc, prev + 2);
    err_q.push_back('{lane: 1'b0, cyc: acc + 1});
    prev = acc;

    // SH on lane 0 at 0x2.
    set_lane(0, 1'b0, 1'b0, 2'b01, 32'h0000_0002, 32'h0000_1234, 5'd12);
    accept(2'b01, got, acc);
    chk("err_next_accept3", acc, prev + 2);
    store_phase(1'b0, 32'h0000_0000, 4'b1100, 32'h1234_1234, 5'd12, acc, 2, gnt);
    tick();

    // Reset while a load waits in WAIT, followed by a late rvalid.
    set_lane(0, 1'b1, 1'b0, 2'b10, 32'h0000_0050, 32'd0, 5'd5);
    accept(2'b01, got, acc);
    e.we = 1'b0; e.addr = 32'h0000_0050; e.be = 4'b1111; e.wdata = 32'd0;
    e.chk_wd = 1'b0; e.cyc = acc + 1;
    mem_q.push_back(e);
    wait_req();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("wrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("wrst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("wrst_mem_addr", mem_addr, 32'd0);
    chk("wrst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("wrst_mem_wdata", mem_wdata, 32'd0);
    chk("wrst_resp_err", {29'd0, resp_valid, err_valid, resp_store}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    tick();

    // After reset lane 0 wins the first conflict again, then lane 1.
    set_lane(0, 1'b0, 1'b0, 2'b00, 32'h0000_0400, 32'h0000_005A, 5'd1);
    set_lane(1, 1'b0, 1'b0, 2'b10, 32'h0000_0500, 32'h0102_0304, 5'd2);
    accept(2'b11, got, acc);
    chk("post_rst_arb0", {31'd0, got}, 32'd0);
    store_phase(1'b0, 32'h0000_0400, 4'b0001, 32'h5A5A_5A5A, 5'd1, acc, 1, gnt);
    accept(2'b11, got, acc);
    chk("post_rst_arb1", {31'd0, got}, 32'd1);
    chk("post_rst_next_accept", acc, gnt + STORE_GAP);
    store_phase(1'b1, 32'h0000_0500, 4'b1111, 32'h0102_0304, 5'd2, acc, 0, gnt);

    repeat (4) tick();
    chk("mem_q_drained", mem_q.size(), 32'd0);
    chk("resp_q_drained", resp_q.size(), 32'd0);
    chk("err_q_drained", err_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Two-lane load/store arbiter and sequencer between the VLIW lanes' decoded memory ops and the single shared data-memory port. It accepts at most one op at a time, choosing between the lanes round-robin, and drives the memory request/grant handshake. It generates byte enables and replicated write data, and aligns and extends load data. It returns load results to the owning lane with a destination tag and flags misaligned or illegal-size ops without touching memory.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of `req_addr` and `mem_addr`.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  2  per-lane op valid; bit i is lane i
- req_ready  out  2  per-lane accept; at most one bit high
- req_is_load  in  2  1 = load, 0 = store
- req_zero_ext  in  2  1 = zero-extend loads (LBU/LHU)
- req_size  in  4  2 bits per lane; 00 byte, 01 half, 10 word, 11 illegal
- req_addr  in  2*ADDR_W  byte address per lane
- req_wdata  in  64  store data per lane, right-justified
- req_rd  in  10  5-bit destination tag per lane
- mem_req  out  1  memory request, held until granted
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  write data, byte/half replicated
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- resp_valid  out  1  one-cycle result pulse
- resp_lane  out  1  owning lane
- resp_rd  out  5  destination tag
- resp_data  out  32  extended load data
- resp_store  out  1  store completion marker (see Configuration)
- err_valid  out  1  one-cycle misalign/illegal-size pulse
- err_lane  out  1  lane of the faulting op

## Operation
- States: IDLE, REQ, WAIT, RESP, ERR.
- IDLE:
  - `req_ready` is high for the selected lane only.
  - With one lane valid, that lane is selected.
  - With both lanes valid, the lane not equal to `last_lane` is selected.
  - On valid & ready, capture all fields and update `last_lane`.
  - Next state is ERR if the op is faulting, else REQ.
- Faulting op:
  - size 11, half with addr[0]=1, or word with addr[1:0]≠0.
  - No memory access is made.
- REQ:
  - `mem_req`=1 with `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` held stable.
  - On `mem_gnt`: a load goes to WAIT; a store goes to IDLE.
- WAIT: on `mem_rvalid`, capture the extended data and go to RESP. `mem_rvalid` is ignored in every other state.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- ERR: `err_valid`=1 and `err_lane` set for exactly one cycle, then IDLE.
- Byte enables (o = addr[1:0]):
  - byte: 4'b0001<<o
  - half: 4'b0011<<(2*addr[1])
  - word: 4'b1111
- Write data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Load data: shift `mem_rdata` right by 8*o, then sign- or zero-extend from bit 7 (byte) or bit 15 (half); word passes unchanged.
- `last_lane` resets to 1, so lane 0 wins the first conflict.

## Timing
- Reset values:
  - All outputs 0, including `req_ready`=0 during reset.
  - State IDLE, `last_lane`=1.
  - Reset mid-operation drops `mem_req` at the next edge and discards any pending op; a late `mem_rvalid` is ignored.
- Accept in cycle N → `mem_req` high at N+1.
- `mem_gnt` in cycle M:
  - Store: IDLE at M+1; next accept possible at M+1.
  - Load: WAIT at M+1.
- `mem_rvalid` is never honoured in the same cycle as `mem_gnt`; it is earliest at M+1.
- `mem_rvalid` at K → `resp_valid` at K+1 → next accept at K+2.
- Faulting op accepted at N → `err_valid` at N+1 → next accept at N+2.
- Only one op is outstanding at a time; there is no buffering beyond the captured op.

## Configuration
- Macro `LSU_ARB_STORE_ACK_EN`.
- Defined:
  - On a store's `mem_gnt`, go to RESP instead of IDLE.
  - RESP drives `resp_valid`=1, `resp_store`=1, `resp_data`=0, `resp_rd`=captured tag.
  - Next accept is at M+2.
- Undefined: stores produce no response, and `resp_store` is tied to 0.

## Test plan
- Lane 0 LB, addr 0x103, rdata 0x80FF_FF11, gnt at cycle 2, rvalid at cycle 4 → `mem_addr`=0x100, `mem_be`=4'b1000, `resp_data`=0xFFFF_FF80, `resp_valid` at cycle 5, `resp_lane`=0.
- Lane 1 LHU, addr 0x2, rdata 0x8001_0000 → `mem_be`=4'b1100, `resp_data`=0x0000_8001.
- Both lanes issue SB, wdata 0xAB, repeatedly from reset → grants alternate 0,1,0,1; `mem_wdata`=0xABAB_ABAB; `mem_we`=1; no `resp_valid` when the macro is undefined.
- SW, addr 0x6 on lane 1 → `err_valid`=1, `err_lane`=1 one cycle after accept; `mem_req` never asserts.
- Load in WAIT, `rst` asserted for 1 cycle, then `mem_rvalid`=1 → no `resp_valid`; all outputs 0; next accept proceeds normally.
- With the macro defined, SH to addr 0x2 granted at cycle M → `resp_valid`=1, `resp_store`=1, `resp_data`=0 at M+1.
